// File: rtl/coef_bram_seq.sv
// Coefficient BRAM sequencer: sweeps WORDS words out of a single-port BRAM into a
// 2-deep output stream and arbitrates host writes. Optional macro: COEF_SEQ_WRITE_INTERLEAVE_EN.
module coef_bram_seq #(
  parameter int DWIDTH = 21,
  parameter int AWIDTH = 5,
  parameter int WORDS  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     host_wr_req,
  input  logic [AWIDTH-1:0]        host_wr_addr,
  input  logic signed [DWIDTH-1:0] host_wr_data,
  output logic                     host_wr_ack,
  output logic                     bram_write,
  output logic [AWIDTH-1:0]        bram_addr,
  output logic signed [DWIDTH-1:0] bram_indata,
  input  logic signed [DWIDTH-1:0] bram_outdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data,
  output logic [AWIDTH-1:0]        out_idx,
  output logic                     out_last
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_start_pend;
  logic [AWIDTH-1:0]          r_addr;
  logic                       r_inflight;
  logic [AWIDTH-1:0]          r_inf_addr;
  logic                       r_inf_last;
  logic signed [DWIDTH-1:0]   r_fifo_data [0:1];
  logic [AWIDTH-1:0]          r_fifo_idx  [0:1];
  logic                       r_fifo_last [0:1];
  logic                       r_wp;
  logic                       r_rp;
  logic [1:0]                 r_count;

  logic                       w_host_gnt;
  logic                       w_go;
  logic                       w_rd_issue;
  logic                       w_done;
  logic                       w_pop;
  logic [2:0]                 w_occ;
  logic                       w_room;

  assign w_pop  = out_valid & out_ready;
  // A word leaving this cycle frees its slot, which keeps one word per cycle flowing.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room = (w_occ < 3'd2);

  // Next-state, port arbitration and sweep read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_host_gnt  = 1'b0;
    w_go        = 1'b0;
    w_rd_issue  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_host_gnt = host_wr_req;
        if (r_start_pend && !host_wr_req) begin
          w_go        = 1'b1;
          w_state_nxt = ST_SWEEP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SWEEP: begin
`ifdef COEF_SEQ_WRITE_INTERLEAVE_EN
        w_host_gnt = host_wr_req;
`else
        w_host_gnt = 1'b0;
`endif
        if (!w_host_gnt && w_room) begin
          w_rd_issue  = 1'b1;
          w_state_nxt = (r_addr == LAST_ADDR) ? ST_DRAIN : ST_SWEEP;
        end else begin
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_DRAIN: begin
`ifdef COEF_SEQ_WRITE_INTERLEAVE_EN
        w_host_gnt = host_wr_req;
`else
        w_host_gnt = 1'b0;
`endif
        if ((r_count == 2'd0) && !r_inflight) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Host-side outputs are forced low while reset is asserted, even with a request present.
  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;
  assign host_wr_ack = w_host_gnt & rst_n;
  assign bram_write  = w_host_gnt & rst_n;
  assign bram_addr   = !rst_n     ? {AWIDTH{1'b0}} :
                       w_host_gnt ? host_wr_addr   :
                       w_rd_issue ? r_addr         : {AWIDTH{1'b0}};
  assign bram_indata = (rst_n && w_host_gnt) ? host_wr_data : {DWIDTH{1'b0}};

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_data[r_rp];
  assign out_idx   = r_fifo_idx[r_rp];
  assign out_last  = r_fifo_last[r_rp];

  // FSM state, pending start and sweep address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_start_pend <= 1'b0;
      r_addr       <= {AWIDTH{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_start_pend <= start | (r_start_pend & ~w_go);
      if (w_go) begin
        r_addr <= {AWIDTH{1'b0}};
      end else if (w_rd_issue) begin
        r_addr <= r_addr + AWIDTH'(1);
      end else begin
        r_addr <= r_addr;
      end
    end
  end

  // In-flight read tag: the BRAM returns data one cycle after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_inf_addr <= {AWIDTH{1'b0}};
      r_inf_last <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      if (w_rd_issue) begin
        r_inf_addr <= r_addr;
        r_inf_last <= (r_addr == LAST_ADDR);
      end else begin
        r_inf_addr <= r_inf_addr;
        r_inf_last <= r_inf_last;
      end
    end
  end

  // Two-entry output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= {DWIDTH{1'b0}};
        r_fifo_idx[i]  <= {AWIDTH{1'b0}};
        r_fifo_last[i] <= 1'b0;
      end
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wp] <= bram_outdata;
        r_fifo_idx[r_wp]  <= r_inf_addr;
        r_fifo_last[r_wp] <= r_inf_last;
        r_wp              <= ~r_wp;
      end else begin
        r_wp <= r_wp;
      end
      r_rp <= w_pop ? ~r_rp : r_rp;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_bram_seq.sv
// Self-checking bench for coef_bram_seq: random coefficients and stream back-pressure
// checked against an array reference of BRAM contents and the expected sweep order.
module tb_coef_bram_seq;
  localparam int DW = 21;
  localparam int AW = 5;
  localparam int NW = 24;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done;
  logic          host_wr_req, host_wr_ack, bram_write;
  logic [AW-1:0] host_wr_addr, bram_addr, out_idx;
  logic [DW-1:0] host_wr_data, bram_indata, bram_outdata, out_data;
  logic          out_valid, out_ready, out_last;

  logic [DW-1:0] bram_mem [0:31];
  logic [DW-1:0] ref_mem  [0:31];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, exp_idx = 0, ready_mode = 0, rphase = 0;
  int done_cyc = -1, ack_cyc = -1, busy_cyc = -1, valid_cyc = -1, last_xfer_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;
  logic [DW-1:0] word5;

  always #5 clk = ~clk;

  coef_bram_seq #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ack(host_wr_ack), .bram_write(bram_write), .bram_addr(bram_addr),
    .bram_indata(bram_indata), .bram_outdata(bram_outdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  // Single-port synchronous BRAM: read data appears one clock after the address.
  always @(posedge clk) begin
    if (bram_write) bram_mem[bram_addr] <= bram_indata;
    bram_outdata <= bram_mem[bram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Observe one cycle mid-period, then cross the clock edge and apply follow-up inputs.
  task automatic step();
    logic clr_req;
    clr_req = 1'b0;
    #2;
    cyc++;
    chk("bram_wr_vs_ack", {63'd0, bram_write}, {63'd0, host_wr_ack});
    if (host_wr_ack) begin
      chk("ack_with_req", host_wr_req, 1);
      chk("fw_addr", bram_addr, host_wr_addr);
      chk("fw_data", bram_indata, host_wr_data);
      ref_mem[host_wr_addr] = host_wr_data;
      ack_cyc = cyc;
      clr_req = 1'b1;
    end
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
      chk("stall_idx", out_idx, prev_idx);
      chk("stall_last", out_last, prev_last);
    end
    if (busy && busy_cyc < 0) busy_cyc = cyc;
    if (out_valid && valid_cyc < 0) valid_cyc = cyc;
    if (out_valid && out_ready) begin
      chk("xfer_in_range", exp_idx < NW, 1);
      chk("out_data", out_data, ref_mem[exp_idx]);
      chk("out_idx", out_idx, exp_idx);
      chk("out_last", out_last, exp_idx == NW - 1);
      if (exp_idx == 5) word5 = out_data;
      last_xfer_cyc = cyc;
      exp_idx++;
    end
    if (done) begin
      chk("done_once", done_cyc < 0, 1);
      done_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_idx;
    prev_last  = out_last;
    @(posedge clk);
    #1;
    if (clr_req) host_wr_req = 1'b0;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rphase++;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g;
    g = 0;
    host_wr_addr = a;
    host_wr_data = d;
    host_wr_req  = 1'b1;
    ack_cyc      = -1;
    while (ack_cyc < 0 && g < 50) begin
      step();
      g++;
    end
    chk("wr_ack_seen", ack_cyc >= 0, 1);
    host_wr_req = 1'b0;
  endtask

  task automatic new_sweep();
    exp_idx = 0; done_cyc = -1; busy_cyc = -1; valid_cyc = -1; last_xfer_cyc = -1;
  endtask

  task automatic run_sweep(input int s0);
    int g;
    g = 0;
    while (done_cyc < 0 && g < 400) begin
      step();
      g++;
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("n_words", exp_idx, NW);
    chk("busy_latency", busy_cyc - s0, 2);
    chk("valid_latency", valid_cyc - busy_cyc, 2);
    chk("done_after_last", done_cyc - last_xfer_cyc, 1);
  endtask

  task automatic start_sweep(output int s0);
    new_sweep();
    start = 1'b1;
    step();
    s0 = cyc;
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {busy, done, host_wr_ack, bram_write, bram_addr, bram_indata,
              out_valid, out_data, out_idx, out_last}, 64'd0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ack"}, host_wr_ack, 0);
  endtask

  initial begin
    int s0, g, wr_cyc;
    logic [DW-1:0] d;
    for (int i = 0; i < 32; i++) begin
      bram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b0;
    host_wr_req = 1'b1; host_wr_addr = 5'd3; host_wr_data = 21'h00ABC;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_init");
    start = 1'b0; host_wr_req = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;

    // Ramp of known coefficients, full-rate stream.
    for (int k = 0; k < NW; k++) host_write(AW'(k), DW'(1000 + k));
    ready_mode = 0;
    start_sweep(s0);
    run_sweep(s0);

    // Negative coefficient with periodic back-pressure.
    host_write(5'd5, 21'h1FFFFF);
    ready_mode = 1; rphase = 0;
    start_sweep(s0);
    run_sweep(s0);
    chk("neg_word5", word5, 21'h1FFFFF);
    chk("neg_word5_signed", $signed(word5) < 0, 1);

    // Random coefficients, random back-pressure.
    for (int k = 0; k < NW; k++) host_write(AW'(k), DW'($urandom));
    ready_mode = 2;
    start_sweep(s0);
    run_sweep(s0);

    // Start and host write in the same idle cycle: the write wins and is swept.
    ready_mode = 0;
    new_sweep();
    d = DW'($urandom);
    host_wr_addr = 5'd7; host_wr_data = d; host_wr_req = 1'b1; ack_cyc = -1;
    start = 1'b1;
    step();
    s0 = cyc;
    start = 1'b0;
    chk("same_cycle_ack", ack_cyc, s0);
    chk("same_cycle_busy", busy, 0);
    run_sweep(s0);
    chk("word7_ref", ref_mem[7], d);

    // Host write to an out-of-range address while a sweep is running.
    start_sweep(s0);
    g = 0;
    while (exp_idx < 4 && g < 50) begin
      step();
      g++;
    end
    d = DW'($urandom);
    host_wr_addr = 5'd30; host_wr_data = d; host_wr_req = 1'b1; ack_cyc = -1;
    wr_cyc = cyc + 1;
    run_sweep(s0);
    g = 0;
    while (ack_cyc < 0 && g < 20) begin
      step();
      g++;
    end
    chk("busy_wr_acked", ack_cyc >= 0, 1);
`ifdef COEF_SEQ_WRITE_INTERLEAVE_EN
    chk("busy_wr_fast", (ack_cyc - wr_cyc) <= 1, 1);
`else
    chk("busy_wr_after_done", ack_cyc, done_cyc + 1);
`endif
    chk("bram30_written", bram_mem[30], d);
    host_wr_req = 1'b0;

    // Reset in the middle of a sweep, then a fresh sweep from index 0.
    start_sweep(s0);
    g = 0;
    while (exp_idx < 11 && g < 60) begin
      step();
      g++;
    end
    chk("reached_idx10", exp_idx, 11);
    host_wr_req = 1'b1; host_wr_addr = 5'd9; host_wr_data = 21'h12345;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    host_wr_req = 1'b0;
    rst_n = 1'b1;
    prev_stall = 1'b0;
    step();
    chk("post_reset_idle", {busy, done, out_valid}, 3'b000);
    start_sweep(s0);
    run_sweep(s0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
